// File: rtl/axi_rab_cfg_regfile_if.sv
// AXI4-Lite bundle (write and read channels) for the RAB configuration register file.
interface axi_rab_cfg_regfile_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64
);
  logic [AXI_ADDR_WIDTH-1:0]   awaddr;
  logic                        awvalid;
  logic                        awready;
  logic [AXI_DATA_WIDTH-1:0]   wdata;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                        wvalid;
  logic                        wready;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  logic [AXI_ADDR_WIDTH-1:0]   araddr;
  logic                        arvalid;
  logic                        arready;
  logic [AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rvalid;
  logic                        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_rab_cfg_regfile.sv
// AXI4-Lite configuration register file for the RAB with independent read/write FSMs.
// Optional macro AXI_RAB_CFG_DECERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axi_rab_cfg_regfile #(
  parameter int N_REGS         = 196,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                                   s_axi_aclk,
  input  logic                                   s_axi_aresetn,
  axi_rab_cfg_regfile_if.slave                   s_axi,
  output logic [N_REGS-1:0][AXI_DATA_WIDTH-1:0]  cfg_regs,
  output logic                                   cfg_wr_pulse,
  output logic [$clog2(N_REGS)-1:0]              cfg_wr_idx
);

  localparam int STRB_W     = AXI_DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_W);
  localparam int IDX_FULL_W = AXI_ADDR_WIDTH - ADDR_LSB;
  localparam int IDX_W      = $clog2(N_REGS);
  localparam logic [IDX_FULL_W-1:0] N_REGS_IDX = IDX_FULL_W'(N_REGS);
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_RAB_CFG_DECERR_EN
  localparam logic [1:0] RESP_RANGE = 2'b10;
`else
  localparam logic [1:0] RESP_RANGE = 2'b00;
`endif

  typedef enum logic [2:0] {
    W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_COMMIT, W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE, R_DATA
  } r_state_e;

  w_state_e w_state, w_next;
  r_state_e r_state, r_next;

  logic [IDX_FULL_W-1:0] aw_idx;
  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic [IDX_FULL_W-1:0] ar_idx;
  logic                  aw_in_range;
  logic                  ar_in_range;
  logic                  unused_addr_lsbs;

  // Sub-word address bits select bytes within a register and carry no meaning here.
  assign unused_addr_lsbs = ^{s_axi.awaddr[ADDR_LSB-1:0], s_axi.araddr[ADDR_LSB-1:0]};

  assign ar_idx      = s_axi.araddr[AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign aw_in_range = (aw_idx < N_REGS_IDX);
  assign ar_in_range = (ar_idx < N_REGS_IDX);

  // ---------------- write path ----------------
  // NOTE: state and data registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) w_state <= W_IDLE;
    else                w_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next        = w_state;
    s_axi.awready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.bvalid  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        s_axi.awready = 1'b1;
        s_axi.wready  = 1'b1;
        if (s_axi.awvalid && s_axi.wvalid) w_next = W_COMMIT;
        else if (s_axi.awvalid)            w_next = W_HAVE_ADDR;
        else if (s_axi.wvalid)             w_next = W_HAVE_DATA;
      end
      W_HAVE_ADDR: begin
        s_axi.wready = 1'b1;
        if (s_axi.wvalid) w_next = W_COMMIT;
      end
      W_HAVE_DATA: begin
        s_axi.awready = 1'b1;
        if (s_axi.awvalid) w_next = W_COMMIT;
      end
      W_COMMIT: w_next = W_RESP;
      W_RESP: begin
        s_axi.bvalid = 1'b1;
        if (s_axi.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      aw_idx <= '0;
      w_data <= '0;
      w_strb <= '0;
    end else begin
      if (s_axi.awvalid && s_axi.awready) aw_idx <= s_axi.awaddr[AXI_ADDR_WIDTH-1:ADDR_LSB];
      if (s_axi.wvalid && s_axi.wready) begin
        w_data <= s_axi.wdata;
        w_strb <= s_axi.wstrb;
      end
    end
  end

  // NOTE: the register array is reset because downstream logic consumes cfg_regs directly.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      cfg_regs     <= '0;
      cfg_wr_pulse <= 1'b0;
      cfg_wr_idx   <= '0;
      s_axi.bresp  <= RESP_OKAY;
    end else begin
      cfg_wr_pulse <= 1'b0;
      if (w_state == W_COMMIT) begin
        if (aw_in_range) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (w_strb[b]) cfg_regs[aw_idx[IDX_W-1:0]][b*8 +: 8] <= w_data[b*8 +: 8];
          end
          cfg_wr_pulse <= 1'b1;
          cfg_wr_idx   <= aw_idx[IDX_W-1:0];
          s_axi.bresp  <= RESP_OKAY;
        end else begin
          s_axi.bresp  <= RESP_RANGE;
        end
      end
    end
  end

  // ---------------- read path ----------------
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) r_state <= R_IDLE;
    else                r_state <= r_next;
  end

  always_comb begin
    r_next        = r_state;
    s_axi.arready = 1'b0;
    s_axi.rvalid  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        s_axi.arready = 1'b1;
        if (s_axi.arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        s_axi.rvalid = 1'b1;
        if (s_axi.rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Sampling cfg_regs here returns the pre-write value when a commit lands on the same edge.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      s_axi.rdata <= '0;
      s_axi.rresp <= RESP_OKAY;
    end else if (s_axi.arvalid && s_axi.arready) begin
      if (ar_in_range) begin
        s_axi.rdata <= cfg_regs[ar_idx[IDX_W-1:0]];
        s_axi.rresp <= RESP_OKAY;
      end else begin
        s_axi.rdata <= '0;
        s_axi.rresp <= RESP_RANGE;
      end
    end
  end

endmodule

// File: tb/tb_axi_rab_cfg_regfile.sv
// Self-checking bench: transaction-level model compared every cycle, plus directed literal checks.
module tb_axi_rab_cfg_regfile;
  localparam int N_REGS = 196;
  localparam int DW     = 64;
  localparam int AW     = 32;
  localparam int IDX_W  = 8;
`ifdef AXI_RAB_CFG_DECERR_EN
  localparam logic [1:0] EXP_ERR = 2'b10;
`else
  localparam logic [1:0] EXP_ERR = 2'b00;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_rab_cfg_regfile_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) s_axi ();
  logic [N_REGS-1:0][DW-1:0] cfg_regs;
  logic                      cfg_wr_pulse;
  logic [IDX_W-1:0]          cfg_wr_idx;

  axi_rab_cfg_regfile #(.N_REGS(N_REGS), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi         (s_axi),
    .cfg_regs      (cfg_regs),
    .cfg_wr_pulse  (cfg_wr_pulse),
    .cfg_wr_idx    (cfg_wr_idx)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [N_REGS-1:0][DW-1:0] m_regs;
  logic [31:0] aw_q[$];
  logic [63:0] wd_q[$];
  logic [7:0]  ws_q[$];
  bit          commit_pend;
  logic [31:0] c_addr;
  logic [63:0] c_data;
  logic [7:0]  c_strb;
  bit          e_bvalid, e_rvalid, e_pulse;
  logic [1:0]  e_bresp, e_rresp;
  logic [63:0] e_rdata;
  logic [IDX_W-1:0] e_idx;

  function automatic bit in_range(input logic [31:0] a);
    return (a >> 3) < N_REGS;
  endfunction

  function automatic bit m_awready();
    return aw_q.size() == 0 && !commit_pend && !e_bvalid;
  endfunction

  function automatic bit m_wready();
    return wd_q.size() == 0 && !commit_pend && !e_bvalid;
  endfunction

  task automatic model_reset();
    aw_q.delete(); wd_q.delete(); ws_q.delete();
    commit_pend = 0; m_regs = '0;
    e_bvalid = 0; e_rvalid = 0; e_pulse = 0;
    e_bresp = 0; e_rresp = 0; e_rdata = 0; e_idx = 0;
  endtask

  task automatic model_step();
    bit aw_hs, w_hs, ar_hs;
    int idx;
    aw_hs = s_axi.awvalid && m_awready();
    w_hs  = s_axi.wvalid && m_wready();
    ar_hs = s_axi.arvalid && !e_rvalid;
    e_pulse = 0;
    if (e_rvalid && s_axi.rready) e_rvalid = 0;
    if (ar_hs) begin
      idx = int'(s_axi.araddr >> 3);
      e_rdata  = in_range(s_axi.araddr) ? m_regs[idx] : 64'h0;
      e_rresp  = in_range(s_axi.araddr) ? 2'b00 : EXP_ERR;
      e_rvalid = 1;
    end
    if (e_bvalid && s_axi.bready) e_bvalid = 0;
    if (commit_pend) begin
      idx = int'(c_addr >> 3);
      if (in_range(c_addr)) begin
        for (int b = 0; b < 8; b++) if (c_strb[b]) m_regs[idx][b*8 +: 8] = c_data[b*8 +: 8];
        e_pulse = 1;
        e_idx   = IDX_W'(idx);
        e_bresp = 2'b00;
      end else begin
        e_bresp = EXP_ERR;
      end
      e_bvalid = 1;
      commit_pend = 0;
    end
    if (aw_hs) aw_q.push_back(s_axi.awaddr);
    if (w_hs) begin
      wd_q.push_back(s_axi.wdata);
      ws_q.push_back(s_axi.wstrb);
    end
    if (aw_q.size() > 0 && wd_q.size() > 0) begin
      c_addr = aw_q.pop_front();
      c_data = wd_q.pop_front();
      c_strb = ws_q.pop_front();
      commit_pend = 1;
    end
  endtask

  initial begin : model
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  function automatic int first_diff();
    for (int k = 0; k < N_REGS; k++) if (cfg_regs[k] !== m_regs[k]) return k;
    return 0;
  endfunction

  initial begin : compare
    int k;
    forever begin
      @(negedge clk);
      check("awready", s_axi.awready, m_awready());
      check("wready", s_axi.wready, m_wready());
      check("arready", s_axi.arready, !e_rvalid);
      check("bvalid", s_axi.bvalid, e_bvalid);
      check("rvalid", s_axi.rvalid, e_rvalid);
      if (e_bvalid) check("bresp", s_axi.bresp, e_bresp);
      if (e_rvalid) begin
        check("rdata", s_axi.rdata, e_rdata);
        check("rresp", s_axi.rresp, e_rresp);
      end
      check("cfg_wr_pulse", cfg_wr_pulse, e_pulse);
      check("cfg_wr_idx", cfg_wr_idx, e_idx);
      k = first_diff();
      check($sformatf("cfg_regs[%0d]", k), cfg_regs[k], m_regs[k]);
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send_aw(input logic [31:0] addr);
    int i;
    s_axi.awaddr = addr; s_axi.awvalid = 1'b1;
    for (i = 0; i < 50 && !s_axi.awready; i++) @(negedge clk);
    check("aw_accept", s_axi.awready, 1'b1);
    @(negedge clk);
    s_axi.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] data, input logic [7:0] strb);
    int i;
    s_axi.wdata = data; s_axi.wstrb = strb; s_axi.wvalid = 1'b1;
    for (i = 0; i < 50 && !s_axi.wready; i++) @(negedge clk);
    check("w_accept", s_axi.wready, 1'b1);
    @(negedge clk);
    s_axi.wvalid = 1'b0;
  endtask

  task automatic wait_bvalid(output int lat);
    lat = 0;
    while (!s_axi.bvalid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("bvalid_seen", s_axi.bvalid, 1'b1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb);
    int lat;
    fork
      send_aw(addr);
      send_w(data, strb);
    join
    wait_bvalid(lat);
    @(negedge clk);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [63:0] data, output logic [1:0] resp);
    int i;
    s_axi.araddr = addr; s_axi.arvalid = 1'b1;
    for (i = 0; i < 50 && !s_axi.arready; i++) @(negedge clk);
    @(negedge clk);
    s_axi.arvalid = 1'b0;
    for (i = 0; i < 50 && !s_axi.rvalid; i++) @(negedge clk);
    check("rvalid_seen", s_axi.rvalid, 1'b1);
    data = s_axi.rdata; resp = s_axi.rresp;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, s_axi.awready, 1'b1);
    check({tag, "_wready"}, s_axi.wready, 1'b1);
    check({tag, "_arready"}, s_axi.arready, 1'b1);
    check({tag, "_bvalid"}, s_axi.bvalid, 1'b0);
    check({tag, "_rvalid"}, s_axi.rvalid, 1'b0);
    check({tag, "_bresp"}, s_axi.bresp, 2'b00);
    check({tag, "_rresp"}, s_axi.rresp, 2'b00);
    check({tag, "_rdata"}, s_axi.rdata, 64'h0);
    check({tag, "_cfg_regs_any"}, |cfg_regs, 1'b0);
    check({tag, "_pulse"}, cfg_wr_pulse, 1'b0);
    check({tag, "_idx"}, cfg_wr_idx, 8'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [63:0] rd;
    logic [1:0]  rr;
    int lat;
    int cnt;
    s_axi.awaddr = '0; s_axi.awvalid = 1'b0;
    s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wvalid = 1'b0;
    s_axi.bready = 1'b1;
    s_axi.araddr = '0; s_axi.arvalid = 1'b0;
    s_axi.rready = 1'b1;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // AW and W together to reg 2: bvalid two cycles after the handshake
    fork
      send_aw(32'h10);
      send_w(64'h1122334455667788, 8'hFF);
    join
    wait_bvalid(lat);
    check("b_latency", lat + 1, 2);
    check("bresp_reg2", s_axi.bresp, 2'b00);
    check("cfg_regs2", cfg_regs[2], 64'h1122334455667788);
    check("pulse_reg2", cfg_wr_pulse, 1'b1);
    check("idx_reg2", cfg_wr_idx, 8'd2);
    @(negedge clk);
    do_read(32'h10, rd, rr);
    check("readback_reg2", rd, 64'h1122334455667788);
    check("readback_resp", rr, 2'b00);

    // W three cycles ahead of AW, low-half strobe to reg 5
    do_write(32'h28, 64'h0, 8'hFF);
    fork
      send_w(64'hAAAAAAAA_BBBBBBBB, 8'h0F);
      begin
        repeat (3) @(negedge clk);
        send_aw(32'h28);
      end
    join
    check("wready_after_w", s_axi.wready, 1'b0);
    wait_bvalid(lat);
    check("wready_during_b", s_axi.wready, 1'b0);
    check("cfg_regs5", cfg_regs[5], 64'h00000000_BBBBBBBB);
    @(negedge clk);

    // low address bits ignored, last register, and partial byte strobe
    do_write(32'h1F, 64'h0BADF00D_CAFEBABE, 8'hFF);
    check("cfg_regs3_lowbits", cfg_regs[3], 64'h0BADF00D_CAFEBABE);
    do_write(32'(195 * 8), 64'h5555_6666_7777_8888, 8'hFF);
    check("cfg_regs195", cfg_regs[195], 64'h5555_6666_7777_8888);
    do_write(32'h10, 64'hAA00_0000_0000_00CC, 8'h81);
    check("cfg_regs2_strb81", cfg_regs[2], 64'hAA22_3344_5566_77CC);

    // zero strobe: data unchanged, pulse still fires
    fork
      send_aw(32'h10);
      send_w(64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    join
    wait_bvalid(lat);
    check("zero_strb_pulse", cfg_wr_pulse, 1'b1);
    check("zero_strb_idx", cfg_wr_idx, 8'd2);
    check("zero_strb_data", cfg_regs[2], 64'hAA22_3344_5566_77CC);
    @(negedge clk);

    // out-of-range write and read
    fork
      send_aw(32'(196 * 8));
      send_w(64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    join
    wait_bvalid(lat);
    check("oor_bresp", s_axi.bresp, EXP_ERR);
    check("oor_no_pulse", cfg_wr_pulse, 1'b0);
    @(negedge clk);
    do_read(32'(196 * 8), rd, rr);
    check("oor_rdata", rd, 64'h0);
    check("oor_rresp", rr, EXP_ERR);

    // read of reg 7 colliding with its commit returns the old value
    do_write(32'h38, 64'h5, 8'hFF);
    s_axi.awaddr = 32'h38; s_axi.awvalid = 1'b1;
    s_axi.wdata = 64'h9; s_axi.wstrb = 8'hFF; s_axi.wvalid = 1'b1;
    @(negedge clk);
    s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
    s_axi.araddr = 32'h38; s_axi.arvalid = 1'b1;
    @(negedge clk);
    s_axi.arvalid = 1'b0;
    check("collide_rvalid", s_axi.rvalid, 1'b1);
    check("collide_rdata_old", s_axi.rdata, 64'h5);
    check("collide_reg7_new", cfg_regs[7], 64'h9);
    @(negedge clk);
    do_read(32'h38, rd, rr);
    check("reg7_after", rd, 64'h9);

    // back-to-back reads with rready high: one transfer every two cycles
    s_axi.araddr = 32'h18; s_axi.arvalid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (s_axi.rvalid) cnt++;
    end
    s_axi.arvalid = 1'b0;
    check("b2b_reads", cnt, 3);
    repeat (2) @(negedge clk);

    // bready held low: response held stable, then reset mid-response
    s_axi.bready = 1'b0;
    fork
      send_aw(32'h20);
      send_w(64'h1234, 8'hFF);
    join
    wait_bvalid(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_bvalid", s_axi.bvalid, 1'b1);
      check("hold_bresp", s_axi.bresp, 2'b00);
      check("hold_awready", s_axi.awready, 1'b0);
      check("hold_wready", s_axi.wready, 1'b0);
    end
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midresp_reset");
    rst_n = 1'b1;
    s_axi.bready = 1'b1;
    @(negedge clk);

    // reset after AW only: the held address is discarded
    send_aw(32'h48);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_w(64'h7777, 8'hFF);
    repeat (3) @(negedge clk);
    check("abort_no_bvalid", s_axi.bvalid, 1'b0);
    check("abort_reg9", cfg_regs[9], 64'h0);
    send_aw(32'h50);
    wait_bvalid(lat);
    check("abort_reg10", cfg_regs[10], 64'h7777);
    check("abort_reg9_after", cfg_regs[9], 64'h0);
    @(negedge clk);

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
